// File: rtl/rs232_tx_wrapper.sv
// Avalon-MM master that feeds a NUM_BYTES-wide word into the RS232 UART TX register,
// MSB byte first. Each byte is preceded by STATUS polls until the TX-ready bit is set.
module rs232_tx_wrapper #(
  parameter int         NUM_BYTES   = 4,
  parameter logic [4:0] RX_BASE     = 5'd0,
  parameter logic [4:0] TX_BASE     = 5'd4,
  parameter logic [4:0] STATUS_BASE = 5'd8,
  parameter int         TX_OK_BIT   = 6,
  localparam int        DATA_W      = 8 * NUM_BYTES
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  output logic [4:0]        avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_done
);

  typedef enum logic [1:0] {S_IDLE, S_POLL, S_WRITE} state_t;

  localparam logic [1:0] LAST = 2'(NUM_BYTES - 1);

  state_t              state, state_n;
  logic [1:0]          cnt, cnt_n;
  logic [DATA_W-1:0]   shift_r, shift_n;
  logic [4:0]          addr_n;
  logic                rd_n, wr_n, done_n;
  logic [31:0]         wd_n;

  // Only the TX-ready bit of STATUS matters; RX_BASE is kept for the register map only.
  logic unused_bits;
  assign unused_bits = ^{avm_readdata, RX_BASE};

  assign o_ready = (state == S_IDLE);

  // State and all bus-facing outputs are registered together.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state         <= S_IDLE;
      cnt           <= 2'd0;
      shift_r       <= '0;
      avm_address   <= STATUS_BASE;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'd0;
      o_done        <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      shift_r       <= shift_n;
      avm_address   <= addr_n;
      avm_read      <= rd_n;
      avm_write     <= wr_n;
      avm_writedata <= wd_n;
      o_done        <= done_n;
    end
  end

  // Next-state and next-output decode; bus signals hold unless the slave completes a transfer.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift_r;
    addr_n  = avm_address;
    rd_n    = avm_read;
    wr_n    = avm_write;
    wd_n    = avm_writedata;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_valid) begin
          shift_n = i_data;
          cnt_n   = 2'd0;
          state_n = S_POLL;
          rd_n    = 1'b1;
          wr_n    = 1'b0;
          addr_n  = STATUS_BASE;
        end
      end
      S_POLL: begin
        // A poll returning not-ready simply repeats the read on the next cycle.
        if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) begin
          state_n = S_WRITE;
          rd_n    = 1'b0;
          wr_n    = 1'b1;
          addr_n  = TX_BASE;
          wd_n    = {24'd0, shift_r[DATA_W-1 -: 8]};
        end
      end
      S_WRITE: begin
        if (!avm_waitrequest) begin
          shift_n = shift_r << 8;
          wr_n    = 1'b0;
          if (cnt == LAST) begin
            state_n = S_IDLE;
            rd_n    = 1'b0;
            done_n  = 1'b1;
            cnt_n   = 2'd0;
          end else begin
            cnt_n   = cnt + 2'd1;
            state_n = S_POLL;
            rd_n    = 1'b1;
            addr_n  = STATUS_BASE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rs232_tx_wrapper.sv
// Randomized and directed bench for rs232_tx_wrapper: a bus-level model tracks the expected
// byte stream and handshake consequences per cycle; directed cases pin latencies literally.
module tb_rs232_tx_wrapper;

  typedef logic [7:0] byte_q_t[$];

  logic        clk, avm_rst;
  logic [4:0]  avm_address;
  logic        avm_read, avm_write, avm_waitrequest;
  logic [31:0] avm_readdata, avm_writedata;
  logic [31:0] i_data;
  logic        i_valid, o_ready, o_done;

  logic [4:0]  b_address;
  logic        b_read, b_write, b_ready, b_done, b_valid;
  logic [31:0] b_writedata;
  logic [15:0] b_data;

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_acc = 0, n_done = 0, acc_cyc = 0, done_cyc = 0;
  int mode = 0, deny = 0, stall = 0, s_wr = 0;
  bit busy = 0;
  logic [7:0] exp_q[$];
  byte_q_t wr_log;

  rs232_tx_wrapper #(.NUM_BYTES(4)) dut (
    .avm_clk(clk), .avm_rst(avm_rst), .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_done(o_done));

  rs232_tx_wrapper #(.NUM_BYTES(2)) dut2 (
    .avm_clk(clk), .avm_rst(avm_rst), .avm_address(b_address), .avm_read(b_read),
    .avm_readdata(32'h0000_0040), .avm_write(b_write), .avm_writedata(b_writedata),
    .avm_waitrequest(1'b0), .i_data(b_data), .i_valid(b_valid),
    .o_ready(b_ready), .o_done(b_done));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave model: waitstates and STATUS contents depend on the current test mode.
  initial begin
    logic [31:0] rnd;
    logic tx_ok, wreq;
    avm_waitrequest = 0;
    avm_readdata = 32'h40;
    forever begin
      @(posedge clk); #1;
      rnd = $urandom;
      wreq = 0;
      tx_ok = 1;
      case (mode)
        1: begin
          wreq  = ($urandom_range(0, 3) == 0);
          tx_ok = ($urandom_range(0, 2) != 0);
        end
        2: if (avm_read && s_wr == 1 && deny > 0) begin
          tx_ok = 0;
          deny--;
        end
        3: if (avm_write) begin
          if (stall < 3) begin wreq = 1; stall++; end
          else stall = 0;
        end
        default: ;
      endcase
      avm_readdata = {rnd[31:7], tx_ok, rnd[5:0]};
      avm_waitrequest = wreq;
      if (avm_write && !wreq) s_wr++;
    end
  end

  // Compare process: each negedge checks the consequences of last cycle's bus events,
  // then records this cycle's events into the model.
  initial begin
    bit p_acc, p_rd_ok, p_rd_no, p_wr_more, p_wr_last, p_stall;
    logic [4:0] pr_addr;
    logic pr_rd, pr_wr;
    logic [31:0] pr_wd, d;
    {p_acc, p_rd_ok, p_rd_no, p_wr_more, p_wr_last, p_stall} = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (avm_rst) begin
        chk("rst_addr", 32'(avm_address), 32'd8);
        chk("rst_read", 32'(avm_read), 0);
        chk("rst_write", 32'(avm_write), 0);
        chk("rst_wdata", avm_writedata, 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_ready", 32'(o_ready), 1);
        busy = 0;
        exp_q.delete();
        {p_acc, p_rd_ok, p_rd_no, p_wr_more, p_wr_last, p_stall} = '0;
      end else begin
        chk("done", 32'(o_done), 32'(p_wr_last));
        chk("ready", 32'(o_ready), 32'(!busy));
        chk("rw_excl", 32'(avm_read & avm_write), 0);
        if (o_done) begin n_done++; done_cyc = cyc; end
        if (p_stall) begin
          chk("hold_rd", 32'(avm_read), 32'(pr_rd));
          chk("hold_wr", 32'(avm_write), 32'(pr_wr));
          chk("hold_addr", 32'(avm_address), 32'(pr_addr));
          if (pr_wr) chk("hold_wd", avm_writedata, pr_wd);
        end else if (p_acc || p_rd_no || p_wr_more) begin
          chk("poll_rd", 32'(avm_read), 1);
          chk("poll_wr", 32'(avm_write), 0);
          chk("poll_addr", 32'(avm_address), 32'd8);
        end else if (p_rd_ok) begin
          chk("wr_start", 32'(avm_write), 1);
          chk("wr_rd", 32'(avm_read), 0);
          chk("wr_addr", 32'(avm_address), 32'd4);
          chk("wr_data", avm_writedata, (exp_q.size() > 0) ? {24'd0, exp_q[0]} : 32'hFFFF_FFFF);
        end else if (!busy) begin
          chk("idle_rd", 32'(avm_read), 0);
          chk("idle_wr", 32'(avm_write), 0);
        end
        // Events of this cycle
        p_acc = i_valid && !busy;
        if (p_acc) begin
          d = i_data;
          for (int k = 0; k < 4; k++) exp_q.push_back(d[31 - 8*k -: 8]);
          busy = 1;
          n_acc++;
          acc_cyc = cyc;
        end
        p_rd_ok = avm_read && !avm_waitrequest && avm_readdata[6];
        p_rd_no = avm_read && !avm_waitrequest && !avm_readdata[6];
        p_wr_more = 0;
        p_wr_last = 0;
        if (avm_write && !avm_waitrequest) begin
          wr_log.push_back(avm_writedata[7:0]);
          chk("wd_hi", {8'd0, avm_writedata[31:8]}, 0);
          if (exp_q.size() == 0) begin
            chk("extra_write", 32'(avm_writedata[7:0]), 32'hFFFF_FFFF);
          end else begin
            chk("byte", 32'(avm_writedata[7:0]), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin p_wr_last = 1; busy = 0; end
            else p_wr_more = 1;
          end
        end
        p_stall = (avm_read || avm_write) && avm_waitrequest;
        pr_addr = avm_address;
        pr_rd   = avm_read;
        pr_wr   = avm_write;
        pr_wd   = avm_writedata;
      end
    end
  end

  task automatic wait_accept(input logic [31:0] w);
    int n0;
    i_valid = 1;
    i_data = w;
    n0 = n_acc;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (n_acc != n0) return;
    end
    chk("accept_timeout", 32'(n_acc), 32'(n0 + 1));
  endtask

  task automatic wait_done(input int n0);
    for (int k = 0; k < 1000; k++) begin
      if (n_done != n0) return;
      @(posedge clk); #1;
    end
    chk("done_timeout", 32'(n_done), 32'(n0 + 1));
  endtask

  task automatic check_log(input string nm, input byte_q_t e);
    chk({nm, "_len"}, 32'(wr_log.size()), 32'(e.size()));
    for (int k = 0; k < e.size(); k++)
      if (k < wr_log.size()) chk(nm, 32'(wr_log[k]), 32'(e[k]));
  endtask

  initial begin
    byte_q_t eb, b_log;
    int nd, b_done_cyc;
    avm_rst = 1;
    i_valid = 0;
    i_data = 0;
    b_valid = 0;
    b_data = 0;
    repeat (3) @(posedge clk);
    #1 avm_rst = 0;
    repeat (2) @(posedge clk);
    #1;

    // T1: zero-wait, always ready
    mode = 0; wr_log.delete(); nd = n_done;
    wait_accept(32'hDEADBEEF); i_valid = 0;
    wait_done(nd);
    chk("t1_latency", 32'(done_cyc - acc_cyc), 32'd9);
    eb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; check_log("t1_byte", eb);

    // T2: five not-ready polls before byte 2
    repeat (2) @(posedge clk); #1;
    mode = 2; deny = 5; s_wr = 0; wr_log.delete(); nd = n_done;
    wait_accept(32'h12345678); i_valid = 0;
    wait_done(nd);
    chk("t2_latency", 32'(done_cyc - acc_cyc), 32'd14);
    eb = '{8'h12, 8'h34, 8'h56, 8'h78}; check_log("t2_byte", eb);

    // T3: three waitstates on each write
    repeat (2) @(posedge clk); #1;
    mode = 3; stall = 0; wr_log.delete(); nd = n_done;
    wait_accept(32'h89ABCDEF); i_valid = 0;
    wait_done(nd);
    chk("t3_latency", 32'(done_cyc - acc_cyc), 32'd21);
    eb = '{8'h89, 8'hAB, 8'hCD, 8'hEF}; check_log("t3_byte", eb);

    // T4: i_valid held, second word taken on the o_done cycle, busy-time data ignored
    repeat (2) @(posedge clk); #1;
    mode = 0; wr_log.delete(); nd = n_done;
    wait_accept(32'h01020304);
    repeat (3) begin i_data = $urandom; @(posedge clk); #1; end
    wait_accept(32'hA0B0C0D0); i_valid = 0;
    chk("t4_b2b", 32'(acc_cyc), 32'(done_cyc));
    wait_done(nd + 1);
    eb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0}; check_log("t4_byte", eb);

    // T5: reset after the second byte aborts the word
    repeat (2) @(posedge clk); #1;
    wr_log.delete(); nd = n_done;
    wait_accept(32'h55667788); i_valid = 0;
    for (int k = 0; k < 100 && wr_log.size() < 2; k++) begin @(posedge clk); #1; end
    chk("t5_two_bytes", 32'(wr_log.size()), 32'd2);
    avm_rst = 1;
    repeat (2) @(posedge clk);
    #1 avm_rst = 0;
    chk("t5_no_done", 32'(n_done), 32'(nd));
    wr_log.delete();
    wait_accept(32'h11223344); i_valid = 0;
    wait_done(nd);
    eb = '{8'h11, 8'h22, 8'h33, 8'h44}; check_log("t5_byte", eb);

    // Randomized slave timing and word traffic
    repeat (2) @(posedge clk); #1;
    mode = 1;
    for (int w = 0; w < 40; w++) begin
      i_valid = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      nd = n_done;
      wait_accept($urandom);
      if ($urandom_range(0, 1) == 1) begin
        i_valid = 0;
        i_data = $urandom;
        wait_done(nd);
      end
    end
    i_valid = 0;
    for (int k = 0; k < 1000 && busy; k++) begin @(posedge clk); #1; end
    chk("rand_drain", 32'(busy), 0);

    // T6: two-byte instance
    mode = 0;
    @(posedge clk); #1;
    b_valid = 1; b_data = 16'hCAFE;
    @(negedge clk);
    chk("t6_ready", 32'(b_ready), 1);
    @(posedge clk); #1;
    b_valid = 0; b_data = 16'h0000;
    b_done_cyc = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (b_write) begin
        b_log.push_back(b_writedata[7:0]);
        chk("t6_wd_hi", {8'd0, b_writedata[31:8]}, 0);
        chk("t6_addr", 32'(b_address), 32'd4);
      end
      if (b_done) b_done_cyc = k;
    end
    chk("t6_latency", 32'(b_done_cyc), 32'd5);
    chk("t6_len", 32'(b_log.size()), 32'd2);
    if (b_log.size() == 2) begin
      chk("t6_b0", 32'(b_log[0]), 32'hCA);
      chk("t6_b1", 32'(b_log[1]), 32'hFE);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
